counter_enable_seq: RTL
=======================

Name: counter_enable_seq

Overview:
Upstream control stage for the 4-bit enable counter. Generates the counter's `enable` as programmable bursts: run length, gap length and burst count are latched at a start request. A busy/done handshake lets a controller or bench launch a counting window and learn when it has finished. Replaces hand-timed enable toggling.

Parameters:
LEN_W, 8, width of run_len and gap_len inputs and of the internal down-counter
CNT_W, 4, width of bursts input and burst_idx output

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  request pulse, sampled on rising clock edge
abort  input  1  synchronous cancel of an active sequence
run_len  input  LEN_W  cycles of enable=1 per burst, latched on accepted start
gap_len  input  LEN_W  cycles of enable=0 between bursts, latched on accepted start
bursts  input  CNT_W  number of bursts, latched on accepted start
enable  output  1  drives downstream counter enable
busy  output  1  high while state is RUN or GAP
done  output  1  one-cycle completion pulse
burst_idx  output  CNT_W  index of current/last burst, 0-based

Behaviour:
- All outputs are registered and decoded from state. reset=0 forces the following immediately, with no clock edge: state IDLE, enable=0, busy=0, done=0, burst_idx=0, internal counters 0.
- States:
  - IDLE: enable=0, busy=0.
  - RUN: enable=1, busy=1.
  - GAP: enable=0, busy=1.
  - DONE: done=1, busy=0, enable=0.
- IDLE, start=1, abort=0 (accepted start): latch run_len, gap_len, bursts; burst_idx<=0.
  - If run_len==0 or bursts==0: go to DONE.
  - Otherwise: go to RUN with cnt<=run_len-1.
- Latency: start accepted at edge k gives enable=1 after edge k. With gap_len==0, enable stays high for exactly run_len*bursts cycles.
- RUN, cnt!=0: cnt decrements.
- RUN, cnt==0:
  - If burst_idx==bursts-1: go to DONE.
  - Else if gap_len==0: stay in RUN, cnt<=run_len-1, burst_idx++. Enable is continuous, with no glitch.
  - Else: go to GAP, cnt<=gap_len-1.
- GAP, cnt!=0: cnt decrements.
- GAP, cnt==0: go to RUN, cnt<=run_len-1, burst_idx++.
- DONE: lasts exactly one cycle, then IDLE. A start seen while in DONE is ignored.
- start while busy: ignored. Latched parameters are unaffected.
- Input changes after an accepted start: no effect on the active sequence.
- abort=1 in RUN or GAP: go to IDLE at the next edge. enable and busy drop after that edge. No done pulse. burst_idx holds its value.
- abort=1 with start=1 in IDLE: abort wins; stay in IDLE.
- burst_idx holds its last value through DONE and IDLE until the next accepted start.
- Reset released mid-operation: resume from IDLE. No done pulse is owed for the interrupted sequence.
- cnt arithmetic is unsigned LEN_W-bit. run_len=2^LEN_W-1 is legal (255 cycles at default).

Optional Feature:
COUNTER_SEQ_PAUSE_EN
- Defined:
  - Adds input port `pause` (1 bit).
  - While pause=1 in RUN or GAP: state, cnt and burst_idx freeze, and enable is 0 from the next edge. busy stays 1.
  - On pause release in RUN: enable=1 after the next edge, and the remaining cycle count is preserved.
  - abort overrides pause.
  - pause has no effect in IDLE or DONE.
- Undefined: `pause` port absent; behaviour exactly as above.

Test Plan:
- run_len=10, gap_len=0, bursts=1, start pulsed for 1 cycle at edge k -> enable=1 for exactly 10 cycles after edge k; busy identical; done=1 for one cycle after edge k+10; downstream 4-bit counter ends at 10.
- run_len=3, gap_len=2, bursts=3 -> enable per cycle 1,1,1,0,0,1,1,1,0,0,1,1,1, then done pulse; burst_idx steps 0,1,2 and holds 2.
- run_len=0, bursts=4 -> enable never rises, busy never rises, done pulses one cycle after start.
- run_len=5: start re-pulsed during cycle 2 of RUN -> ignored, enable still 5 cycles; separate run with abort during cycle 3 -> enable and busy low next cycle, no done.
- reset driven low mid-RUN between clock edges -> enable, busy, done, burst_idx all 0 immediately; after release, stays IDLE until start.
- With COUNTER_SEQ_PAUSE_EN defined: run_len=6, pause held 4 cycles after 2 enabled cycles -> enable=1 for total 6 cycles, done delayed by 4 cycles.

Source files
------------

// File: rtl/counter_enable_seq.sv
// counter_enable_seq
//   Burst generator for the downstream 4-bit counter enable. A start request
//   latches run length, gap length and burst count; the block then emits
//   `bursts` runs of enable=1, each `run_len` cycles long, separated by
//   `gap_len` cycles of enable=0, and finishes with a one-cycle done pulse.
//
//   Optional feature macro: COUNTER_SEQ_PAUSE_EN (adds the `pause` input,
//   which freezes an active sequence and holds enable low while asserted).
//
// Ports
//   clock      system clock, rising edge
//   reset      asynchronous active-low reset
//   start      start request, accepted only in IDLE and only without abort
//   abort      synchronous cancel of an active sequence (no done pulse)
//   pause      (COUNTER_SEQ_PAUSE_EN only) freeze while in RUN/GAP
//   run_len    enable-high cycles per burst
//   gap_len    enable-low cycles between bursts
//   bursts     number of bursts
//   enable     downstream counter enable (registered)
//   busy       high while a sequence is in RUN or GAP (registered)
//   done       one-cycle completion pulse (registered)
//   burst_idx  0-based index of the current/last burst
module counter_enable_seq #(
   parameter int LEN_W = 8,
   parameter int CNT_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
`ifdef COUNTER_SEQ_PAUSE_EN
   input  logic             pause,
`endif
   input  logic [LEN_W-1:0] run_len,
   input  logic [LEN_W-1:0] gap_len,
   input  logic [CNT_W-1:0] bursts,
   output logic             enable,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] burst_idx
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] run_len_q, run_len_d;
   logic [LEN_W-1:0] gap_len_q, gap_len_d;
   logic [CNT_W-1:0] bursts_q, bursts_d;
   logic [CNT_W-1:0] burst_idx_q, burst_idx_d;
   logic             enable_q, enable_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             pause_in;
   logic             active;
   logic             freeze;

`ifdef COUNTER_SEQ_PAUSE_EN
   assign pause_in = pause;
`else
   assign pause_in = 1'b0;
`endif

   assign active = (state_q == S_RUN) || (state_q == S_GAP);
   // abort takes priority over pause; pause is meaningless outside RUN/GAP
   assign freeze = pause_in && active && !abort;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      run_len_d   = run_len_q;
      gap_len_d   = gap_len_q;
      bursts_d    = bursts_q;
      burst_idx_d = burst_idx_q;

      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               run_len_d   = run_len;
               gap_len_d   = gap_len;
               bursts_d    = bursts;
               burst_idx_d = '0;
               if (run_len == '0 || bursts == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_RUN;
                  cnt_d   = run_len - LEN_W'(1);
               end
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (!freeze) begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - LEN_W'(1);
               end else if (burst_idx_q == bursts_q - CNT_W'(1)) begin
                  state_d = S_DONE;
               end else if (gap_len_q == '0) begin
                  // back-to-back bursts: stay in RUN so enable never dips
                  cnt_d       = run_len_q - LEN_W'(1);
                  burst_idx_d = burst_idx_q + CNT_W'(1);
               end else begin
                  state_d = S_GAP;
                  cnt_d   = gap_len_q - LEN_W'(1);
               end
            end
         end
         S_GAP: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (!freeze) begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - LEN_W'(1);
               end else begin
                  state_d     = S_RUN;
                  cnt_d       = run_len_q - LEN_W'(1);
                  burst_idx_d = burst_idx_q + CNT_W'(1);
               end
            end
         end
         default: begin
            // DONE lasts one cycle; a start seen here is dropped
            state_d = S_IDLE;
         end
      endcase

      // outputs are registered copies of the next-state decode; a frozen
      // RUN reports enable=0 so the downstream counter stops with it
      enable_d = (state_d == S_RUN) && !freeze;
      busy_d   = (state_d == S_RUN) || (state_d == S_GAP);
      done_d   = (state_d == S_DONE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         run_len_q   <= '0;
         gap_len_q   <= '0;
         bursts_q    <= '0;
         burst_idx_q <= '0;
         enable_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         run_len_q   <= run_len_d;
         gap_len_q   <= gap_len_d;
         bursts_q    <= bursts_d;
         burst_idx_q <= burst_idx_d;
         enable_q    <= enable_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign enable    = enable_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign burst_idx = burst_idx_q;

endmodule
